// File: rtl/arbitro_rr_pkg.sv
// arbitro_rr shared types: FSM state encoding and channel geometry.
// Optional ARB_STATS_EN adds per-VC grant counters in the top level.
package arbitro_rr_pkg;

    localparam int N_VC   = 4;
    localparam int DEST_W = 2;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

    function automatic logic [N_VC-1:0] onehot4(input logic [DEST_W-1:0] i);
        return 4'b0001 << i;
    endfunction

endpackage

// File: rtl/arbitro_rr_pick4.sv
// Rotating-priority picker: first set bit of eligible at or after start.
module rr_pick4
    import arbitro_rr_pkg::*;
(
    input  logic [3:0] eligible,
    input  logic [1:0] start,
    output logic       valid,
    output logic [1:0] idx
);

    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] off;

    // rot[k] is eligible[(start+k) mod 4]
    assign dbl = {eligible, eligible};
    assign rot = dbl[{1'b0, start} +: 4];

    always_comb begin
        valid = |rot;
        off   = 2'd0;
        if (rot[0])      off = 2'd0;
        else if (rot[1]) off = 2'd1;
        else if (rot[2]) off = 2'd2;
        else if (rot[3]) off = 2'd3;
        idx = start + off;
    end

endmodule

// File: rtl/arbitro_rr.sv
// Round-robin VC arbiter routing head words to destination output FIFOs.
// Define ARB_STATS_EN to add saturating per-VC grant counters (stat_grants).
module arbitro_rr
    import arbitro_rr_pkg::*;
#(
    parameter int DATA_W = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     active_in,
    input  logic [N_VC-1:0]          in_empty,
    input  logic [N_VC*DATA_W-1:0]   in_data,
    output logic [N_VC-1:0]          in_pop,
    input  logic [N_VC-1:0]          out_almost_full,
    output logic [N_VC-1:0]          out_push,
    output logic [DATA_W-1:0]        out_data,
    output logic [1:0]               grant_id,
    output logic                     busy
`ifdef ARB_STATS_EN
    ,
    output logic [N_VC*8-1:0]        stat_grants
`endif
);

    state_t             state;
    logic [1:0]         last_grant;
    logic [DATA_W-1:0]  head [N_VC];
    logic [N_VC-1:0]    eligible;
    logic [1:0]         start;
    logic               pick_valid;
    logic [1:0]         pick_idx;
    logic               grant;
    logic [DATA_W-1:0]  pick_word;

    always_comb begin
        for (int i = 0; i < N_VC; i++) begin
            head[i]     = in_data[i*DATA_W +: DATA_W];
            eligible[i] = !in_empty[i] &&
                          !out_almost_full[head[i][DATA_W-1 -: DEST_W]];
        end
    end

    assign start = last_grant + 2'd1;

    rr_pick4 u_pick (
        .eligible (eligible),
        .start    (start),
        .valid    (pick_valid),
        .idx      (pick_idx)
    );

    // Reset gates the pop so no word leaves an input FIFO while held in reset
    assign grant     = !reset && active_in && (state != ST_OFF) && pick_valid;
    assign pick_word = head[pick_idx];
    assign in_pop    = grant ? onehot4(pick_idx) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_OFF;
            last_grant <= 2'd3;
            out_push   <= '0;
            out_data   <= '0;
            grant_id   <= 2'd0;
            busy       <= 1'b0;
        end else begin
            out_push <= grant ? onehot4(pick_word[DATA_W-1 -: DEST_W]) : '0;
            if (grant) begin
                out_data   <= pick_word;
                grant_id   <= pick_idx;
                last_grant <= pick_idx;
            end
            unique case (state)
                ST_OFF: begin
                    state <= active_in ? ST_IDLE : ST_OFF;
                    busy  <= 1'b0;
                end
                ST_IDLE, ST_SERVE: begin
                    if (!active_in) begin
                        state <= ST_OFF;
                        busy  <= 1'b0;
                    end else if (grant) begin
                        state <= ST_SERVE;
                        busy  <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_OFF;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_grants <= '0;
        end else begin
            for (int i = 0; i < N_VC; i++) begin
                if (in_pop[i] && stat_grants[i*8 +: 8] != 8'hFF)
                    stat_grants[i*8 +: 8] <= stat_grants[i*8 +: 8] + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_arbitro_rr.sv
// Scoreboard bench for arbitro_rr: directed vectors, queued expectations.
module tb_arbitro_rr;

    localparam int DW = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic            active_in;
    logic [3:0]      in_empty;
    logic [4*DW-1:0] in_data;
    logic [3:0]      in_pop;
    logic [3:0]      out_almost_full;
    logic [3:0]      out_push;
    logic [DW-1:0]   out_data;
    logic [1:0]      grant_id;
    logic            busy;
`ifdef ARB_STATS_EN
    logic [31:0]     stat_grants;
`endif

    arbitro_rr #(.DATA_W(DW)) dut (
        .clk             (clk),
        .reset           (reset),
        .active_in       (active_in),
        .in_empty        (in_empty),
        .in_data         (in_data),
        .in_pop          (in_pop),
        .out_almost_full (out_almost_full),
        .out_push        (out_push),
        .out_data        (out_data),
        .grant_id        (grant_id),
        .busy            (busy)
`ifdef ARB_STATS_EN
        ,
        .stat_grants     (stat_grants)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    push;
        logic [DW-1:0] data;
        logic [1:0]    gid;
    } exp_t;

    exp_t          exp_q [$];
    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];
    logic [DW-1:0] q2 [$];
    logic [DW-1:0] q3 [$];
    int            checks   = 0;
    int            failures = 0;
    bit            sb_on    = 1'b1;
    int            npush    = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] w(input logic [1:0] d, input logic [7:0] lo);
        return {d, lo};
    endfunction

    task automatic refresh();
        in_empty[0] = (q0.size() == 0);
        in_empty[1] = (q1.size() == 0);
        in_empty[2] = (q2.size() == 0);
        in_empty[3] = (q3.size() == 0);
        in_data[0*DW +: DW] = (q0.size() != 0) ? q0[0] : '0;
        in_data[1*DW +: DW] = (q1.size() != 0) ? q1[0] : '0;
        in_data[2*DW +: DW] = (q2.size() != 0) ? q2[0] : '0;
        in_data[3*DW +: DW] = (q3.size() != 0) ? q3[0] : '0;
    endtask

    task automatic load(input int vc, input logic [DW-1:0] word);
        case (vc)
            0: q0.push_back(word);
            1: q1.push_back(word);
            2: q2.push_back(word);
            default: q3.push_back(word);
        endcase
    endtask

    task automatic expect_push(input logic [3:0] p, input logic [DW-1:0] d,
                               input logic [1:0] g);
        exp_t e;
        e.push = p;
        e.data = d;
        e.gid  = g;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        chk({name, "_drain"}, exp_q.size(), 0);
        step();
        step();
    endtask

    // Input FIFO model: pops whatever in_pop requested just before the edge
    initial begin
        logic [3:0] p;
        forever begin
            @(negedge clk);
            #4;
            p = in_pop;
            @(posedge clk);
            #1;
            if (p[0]) void'(q0.pop_front());
            if (p[1]) void'(q1.pop_front());
            if (p[2]) void'(q2.pop_front());
            if (p[3]) void'(q3.pop_front());
            refresh();
        end
    end

    always @(negedge clk) begin
        if (out_push != 4'b0000) begin
            if (!sb_on) begin
                npush++;
            end else if (exp_q.size() == 0) begin
                chk("unexpected_push", {28'd0, out_push}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_push", {28'd0, out_push}, {28'd0, e.push});
                chk("out_data", {22'd0, out_data}, {22'd0, e.data});
                chk("grant_id", {30'd0, grant_id}, {30'd0, e.gid});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=done");
        $fatal(1, "timeout");
    end

    initial begin
        reset           = 1'b1;
        active_in       = 1'b0;
        out_almost_full = 4'b0000;
        refresh();
        repeat (3) @(posedge clk);
        step();
        chk("rst_in_pop",   {28'd0, in_pop},    0);
        chk("rst_out_push", {28'd0, out_push},  0);
        chk("rst_out_data", {22'd0, out_data},  0);
        chk("rst_grant_id", {30'd0, grant_id},  0);
        chk("rst_busy",     {31'd0, busy},      0);
        chk("rst_state",    32'(dut.state),     0);
        reset = 1'b0;

        // Active link with every input empty stays idle
        active_in = 1'b1;
        repeat (4) step();
        chk("idle_state",  32'(dut.state),  1);
        chk("idle_in_pop", {28'd0, in_pop}, 0);
        chk("idle_busy",   {31'd0, busy},   0);

        // All four VCs eligible: strict 0,1,2,3 rotation
        for (int i = 0; i < 4; i++) begin
            load(i, w(2'(i), 8'hA0 + 8'(i)));
        end
        refresh();
        expect_push(4'b0001, w(2'd0, 8'hA0), 2'd0);
        expect_push(4'b0010, w(2'd1, 8'hA1), 2'd1);
        expect_push(4'b0100, w(2'd2, 8'hA2), 2'd2);
        expect_push(4'b1000, w(2'd3, 8'hA3), 2'd3);
        #1;
        chk("rr_pop0", {28'd0, in_pop}, 32'b0001);
        step();
        chk("rr_pop1", {28'd0, in_pop}, 32'b0010);
        chk("rr_busy", {31'd0, busy}, 1);
        step();
        chk("rr_pop2", {28'd0, in_pop}, 32'b0100);
        step();
        chk("rr_pop3", {28'd0, in_pop}, 32'b1000);
        step();
        chk("rr_pop_end", {28'd0, in_pop}, 0);
        wait_drain("rr");

        // VC1 targets almost-full dest 2 and is skipped without blocking others
        out_almost_full = 4'b0100;
        load(0, w(2'd0, 8'hB0));
        load(0, w(2'd1, 8'hB4));
        load(1, w(2'd2, 8'hB1));
        load(2, w(2'd3, 8'hB2));
        load(3, w(2'd1, 8'hB3));
        refresh();
        expect_push(4'b0001, w(2'd0, 8'hB0), 2'd0);
        expect_push(4'b1000, w(2'd3, 8'hB2), 2'd2);
        expect_push(4'b0010, w(2'd1, 8'hB3), 2'd3);
        expect_push(4'b0010, w(2'd1, 8'hB4), 2'd0);
        #1;
        chk("af_pop0", {28'd0, in_pop}, 32'b0001);
        step();
        chk("af_pop1", {28'd0, in_pop}, 32'b0100);
        repeat (5) step();
        chk("af_blocked_pop",  {28'd0, in_pop}, 0);
        chk("af_blocked_busy", {31'd0, busy},   0);
        chk("af_blocked_sb",   exp_q.size(),    0);
        out_almost_full = 4'b0000;
        expect_push(4'b0100, w(2'd2, 8'hB1), 2'd1);
        #1;
        chk("af_release_pop", {28'd0, in_pop}, 32'b0010);
        wait_drain("af");

        // Link drops one cycle after a pop; the popped word still lands
        load(2, w(2'd0, 8'hC2));
        load(3, w(2'd1, 8'hC3));
        refresh();
        expect_push(4'b0001, w(2'd0, 8'hC2), 2'd2);
        #1;
        chk("drop_pop0", {28'd0, in_pop}, 32'b0100);
        step();
        chk("drop_busy_serve", {31'd0, busy}, 1);
        chk("drop_next_pop", {28'd0, in_pop}, 32'b1000);
        active_in = 1'b0;
        #1;
        chk("drop_pop_gated", {28'd0, in_pop}, 0);
        step();
        step();
        chk("drop_state", 32'(dut.state), 0);
        chk("drop_busy",  {31'd0, busy},     0);
        chk("drop_pop",   {28'd0, in_pop},   0);
        chk("drop_push",  {28'd0, out_push}, 0);
        chk("drop_sb",    exp_q.size(),      0);
        q3.delete();
        refresh();

        // Async reset mid-stream kills the in-flight word; restart at VC0
        for (int i = 0; i < 4; i++) begin
            load(i, w(2'(i), 8'hD0 + 8'(i)));
            load(i, w(2'(i), 8'hE0 + 8'(i)));
        end
        refresh();
        active_in = 1'b1;
        expect_push(4'b1000, w(2'd3, 8'hD3), 2'd3);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_out_push", {28'd0, out_push}, 0);
        chk("ar_busy",     {31'd0, busy},     0);
        chk("ar_in_pop",   {28'd0, in_pop},   0);
        chk("ar_sb",       exp_q.size(),      0);
        expect_push(4'b0001, w(2'd0, 8'hE0), 2'd0);
        expect_push(4'b0010, w(2'd1, 8'hD1), 2'd1);
        expect_push(4'b0100, w(2'd2, 8'hD2), 2'd2);
        expect_push(4'b1000, w(2'd3, 8'hE3), 2'd3);
        expect_push(4'b0010, w(2'd1, 8'hE1), 2'd1);
        expect_push(4'b0100, w(2'd2, 8'hE2), 2'd2);
        step();
        reset = 1'b0;
        step();
        chk("ar_first_pop", {28'd0, in_pop}, 32'b0001);
        wait_drain("ar");

`ifdef ARB_STATS_EN
        // Counter saturation on VC2, exact counts elsewhere
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb_on = 1'b0;
        npush = 0;
        for (int i = 0; i < 4; i++) load(0, w(2'd0, 8'(i)));
        for (int i = 0; i < 300; i++) load(2, w(2'd0, 8'(i)));
        load(3, w(2'd0, 8'h33));
        refresh();
        begin
            int n;
            n = 0;
            while ((q0.size() + q2.size() + q3.size()) != 0 && n < 500) begin
                step();
                n++;
            end
        end
        repeat (3) step();
        chk("st_npush", npush, 305);
        chk("st_vc0", {24'd0, stat_grants[7:0]},   4);
        chk("st_vc1", {24'd0, stat_grants[15:8]},  0);
        chk("st_vc2", {24'd0, stat_grants[23:16]}, 255);
        chk("st_vc3", {24'd0, stat_grants[31:24]}, 1);
        sb_on = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
